// File: rtl/dist_rd_burst_ctrl_if.sv
// Signal bundle for dist_rd_burst_ctrl: command/status, AXI4 AR and R channels,
// the output stream and the stall counter. master = controller side, slave = environment.
interface dist_rd_burst_ctrl_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 512,
  parameter int LEN_W  = 32
);
  logic              ctrl_start;
  logic [ADDR_W-1:0] ctrl_addr;
  logic [LEN_W-1:0]  ctrl_beats;
  logic              ctrl_busy;
  logic              ctrl_done;
  logic              ctrl_err;

  logic [ADDR_W-1:0] m_axi_ARADDR;
  logic [7:0]        m_axi_ARLEN;
  logic [2:0]        m_axi_ARSIZE;
  logic [1:0]        m_axi_ARBURST;
  logic              m_axi_ARVALID;
  logic              m_axi_ARREADY;

  logic [DATA_W-1:0] m_axi_RDATA;
  logic [1:0]        m_axi_RRESP;
  logic              m_axi_RLAST;
  logic              m_axi_RVALID;
  logic              m_axi_RREADY;

  logic [DATA_W-1:0] out_tdata;
  logic              out_tvalid;
  logic              out_tready;
  logic              out_tlast;

  logic [31:0]       perf_stall_cycles;

  modport master (
    input  ctrl_start, ctrl_addr, ctrl_beats,
    output ctrl_busy, ctrl_done, ctrl_err,
    output m_axi_ARADDR, m_axi_ARLEN, m_axi_ARSIZE, m_axi_ARBURST, m_axi_ARVALID,
    input  m_axi_ARREADY,
    input  m_axi_RDATA, m_axi_RRESP, m_axi_RLAST, m_axi_RVALID,
    output m_axi_RREADY,
    output out_tdata, out_tvalid, out_tlast,
    input  out_tready,
    output perf_stall_cycles
  );

  modport slave (
    output ctrl_start, ctrl_addr, ctrl_beats,
    input  ctrl_busy, ctrl_done, ctrl_err,
    input  m_axi_ARADDR, m_axi_ARLEN, m_axi_ARSIZE, m_axi_ARBURST, m_axi_ARVALID,
    output m_axi_ARREADY,
    output m_axi_RDATA, m_axi_RRESP, m_axi_RLAST, m_axi_RVALID,
    input  m_axi_RREADY,
    input  out_tdata, out_tvalid, out_tlast,
    output out_tready,
    input  perf_stall_cycles
  );
endinterface

// File: rtl/dist_rd_burst_ctrl.sv
// AXI4 read-burst scheduler: splits one (addr, beats) command into 4 KB-safe bursts and
// streams R data through. Define DIST_RD_PERF_EN to build the stall-cycle counter.
module dist_rd_burst_ctrl #(
  parameter int ADDR_W          = 64,
  parameter int DATA_W          = 512,
  parameter int LEN_W           = 32,
  parameter int MAX_BURST       = 64,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  dist_rd_burst_ctrl_if.master  bus
);

  localparam int BEAT_BYTES = DATA_W / 8;
  localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);
  localparam int OST_W      = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_rem;
  logic [LEN_W-1:0]  r_beats;
  logic [LEN_W-1:0]  r_rcvd;
  logic [OST_W-1:0]  r_ost;
  logic              r_err;

  logic              w_busy;
  logic              w_done;
  logic              w_arvalid;
  logic              w_accept;
  logic              w_ar_hs;
  logic              w_rready;
  logic              w_tvalid;
  logic              w_r_hs;
  logic              w_r_retire;
  logic [12:0]       w_bdist;
  logic [12:0]       w_cap;
  logic [12:0]       w_len;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic              w_tlast;

  // Burst length = min(remaining, MAX_BURST, beats left before the next 4 KB page).
  assign w_bdist    = (13'h1000 - {1'b0, r_addr[11:0]}) >> BEAT_SHIFT;
  assign w_cap      = (w_bdist < 13'(MAX_BURST)) ? w_bdist : 13'(MAX_BURST);
  assign w_len      = (r_rem < LEN_W'(w_cap)) ? r_rem[12:0] : w_cap;
  assign w_addr_nxt = r_addr + (ADDR_W'(w_len) << BEAT_SHIFT);

  assign w_accept   = (r_state == S_IDLE) & bus.ctrl_start;
  assign w_ar_hs    = w_arvalid & bus.m_axi_ARREADY;
  assign w_rready   = bus.out_tready & w_busy;
  assign w_tvalid   = bus.m_axi_RVALID & w_busy;
  assign w_r_hs     = bus.m_axi_RVALID & w_rready;
  assign w_r_retire = w_r_hs & bus.m_axi_RLAST;
  assign w_tlast    = w_busy & (({1'b0, r_rcvd} + (LEN_W + 1)'(1)) == {1'b0, r_beats});

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // AR is driven straight from registered state, so address/length are held while stalled.
  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    w_arvalid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.ctrl_start) w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        w_busy    = 1'b1;
        w_arvalid = (r_rem != '0) && (r_ost < OST_W'(MAX_OUTSTANDING));
        if (r_rem == '0) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        w_busy = 1'b1;
        if ((r_ost == '0) && (r_rcvd == r_beats)) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_busy      = 1'b1;
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_addr  <= '0;
      r_rem   <= '0;
      r_beats <= '0;
      r_rcvd  <= '0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_addr  <= bus.ctrl_addr;
      r_rem   <= bus.ctrl_beats;
      r_beats <= bus.ctrl_beats;
      r_rcvd  <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_ar_hs) begin
        r_addr <= w_addr_nxt;
        r_rem  <= r_rem - LEN_W'(w_len);
      end
      if (w_r_hs) begin
        r_rcvd <= r_rcvd + LEN_W'(1);
        if (bus.m_axi_RRESP != 2'b00) r_err <= 1'b1;
      end
    end
  end

  // A new AR and a retiring RLAST in the same cycle cancel out.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_ost <= '0;
    end else if (w_ar_hs && !w_r_retire) begin
      r_ost <= r_ost + OST_W'(1);
    end else if (!w_ar_hs && w_r_retire && (r_ost != '0)) begin
      r_ost <= r_ost - OST_W'(1);
    end
  end

`ifdef DIST_RD_PERF_EN
  logic [31:0] r_stall;
  logic        w_stall;

  assign w_stall = w_busy & ((w_arvalid & ~bus.m_axi_ARREADY) | (w_tvalid & ~bus.out_tready));

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_stall <= '0;
    end else if (w_accept) begin
      r_stall <= '0;
    end else if (w_stall && (r_stall != '1)) begin
      r_stall <= r_stall + 32'd1;
    end
  end

  assign bus.perf_stall_cycles = r_stall;
`else
  assign bus.perf_stall_cycles = '0;
`endif

  assign bus.ctrl_busy     = w_busy;
  assign bus.ctrl_done     = w_done;
  assign bus.ctrl_err      = r_err;

  assign bus.m_axi_ARVALID = w_arvalid;
  assign bus.m_axi_ARADDR  = r_addr;
  assign bus.m_axi_ARLEN   = w_arvalid ? 8'(w_len - 13'd1) : 8'd0;
  assign bus.m_axi_ARSIZE  = 3'(BEAT_SHIFT);
  assign bus.m_axi_ARBURST = 2'b01;

  assign bus.m_axi_RREADY  = w_rready;
  assign bus.out_tdata     = bus.m_axi_RDATA;
  assign bus.out_tvalid    = w_tvalid;
  assign bus.out_tlast     = w_tlast;

endmodule

// File: doc/dist_rd_burst_ctrl.md
Name: dist_rd_burst_ctrl

Overview:
AXI4 read-burst scheduler for one 512-bit gmem read master of the distance kernel.
- Takes a single transfer command (base address, length in beats) from kernel control logic.
- Splits the command into legal AR bursts: max 64 beats, no 4 KB crossing, bounded outstanding count.
- Forwards R data to the compute datapath as a stream and reports completion and error status.

Parameters:
ADDR_W, 64, AXI address width
DATA_W, 512, AXI/stream data width; beat = DATA_W/8 bytes
LEN_W, 32, width of command beat count
MAX_BURST, 64, max beats per AR burst (≤256, power of two)
MAX_OUTSTANDING, 8, max AR bursts issued but not fully received

Ports:
ap_clk  in  1  kernel clock, all logic rising-edge
ap_rst  in  1  synchronous, active-high reset
ctrl_start  in  1  command strobe; accepted only when ctrl_busy=0
ctrl_addr  in  ADDR_W  base byte address, aligned to DATA_W/8
ctrl_beats  in  LEN_W  transfer length in beats
ctrl_busy  out  1  command in progress
ctrl_done  out  1  one-cycle completion pulse
ctrl_err  out  1  sticky: any RRESP≠OKAY in last transfer
m_axi_ARADDR  out  ADDR_W  burst address
m_axi_ARLEN  out  8  beats-1
m_axi_ARSIZE  out  3  constant log2(DATA_W/8)
m_axi_ARBURST  out  2  constant 2'b01 (INCR)
m_axi_ARVALID  out  1  AR valid
m_axi_ARREADY  in  1  AR ready
m_axi_RDATA  in  DATA_W  read data
m_axi_RRESP  in  2  read response
m_axi_RLAST  in  1  last beat of burst
m_axi_RVALID  in  1  R valid
m_axi_RREADY  out  1  R ready
out_tdata  out  DATA_W  stream data (=RDATA)
out_tvalid  out  1  stream valid (=RVALID while busy)
out_tready  in  1  stream ready
out_tlast  out  1  final beat of whole transfer
perf_stall_cycles  out  32  stall counter (optional feature)

Behaviour:
- Reset values: ctrl_busy=0, ctrl_done=0, ctrl_err=0, ARVALID=0, ARADDR=0, ARLEN=0, perf_stall_cycles=0. State returns to IDLE and all counters clear.
- Reset mid-transfer abandons the transfer. No draining of in-flight R beats; interconnect reset is a system-level requirement.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
  - IDLE: on ctrl_start, latch addr/beats, clear ctrl_err, busy=1, go to ISSUE.
  - ISSUE: burst length = min(remaining beats, MAX_BURST, beats to next 4 KB boundary). Boundary distance = (4096 - addr[11:0]) / (DATA_W/8).
    - ARVALID rises the cycle after start is accepted.
    - ARADDR/ARLEN stay stable while ARVALID=1 && ARREADY=0.
    - On AR handshake: addr += len*beat_bytes, remaining -= len, outstanding++.
    - Next burst is presented the cycle after a handshake, provided outstanding < MAX_OUTSTANDING; otherwise ARVALID=0 until a burst retires.
    - When remaining reaches 0, go to DRAIN.
  - DRAIN: wait until outstanding==0 and received beats == ctrl_beats, then go to DONE.
  - DONE: ctrl_done=1 for exactly one cycle, busy=0 on the following cycle, go to IDLE.
- ctrl_beats=0: IDLE→ISSUE→DRAIN→DONE with no AR issued; ctrl_done pulses 3 cycles after start.
- ctrl_start while busy is ignored; no queuing.
- Outstanding counter:
  - +1 on AR handshake; -1 on R handshake with RLAST.
  - Both in the same cycle: unchanged.
  - Never exceeds MAX_OUTSTANDING.
- R path is combinational pass-through with no buffering:
  - RREADY = out_tready & busy.
  - out_tvalid = RVALID & busy.
- out_tlast asserts on the beat whose handshake makes received count = ctrl_beats.
- Any R handshake with RRESP≠0 sets ctrl_err. It holds through ctrl_done and clears on the next accepted start.
- Beat counters are LEN_W wide; ctrl_beats up to 2^LEN_W-1 must work with no wrap.

Optional Feature:
DIST_RD_PERF_EN
- Defined: perf_stall_cycles counts cycles while busy where (ARVALID & ~ARREADY) | (out_tvalid & ~out_tready). Clears on accepted start; saturates at 0xFFFFFFFF.
- Undefined: the port is tied to 0 and no counter logic is synthesized.

Test Plan:
1. addr=0x1000, beats=16, ARREADY=1, out_tready=1 → one AR: ARADDR=0x1000, ARLEN=15. 16 stream beats, tlast on beat 16, ctrl_done 2 cycles after the last R handshake, ctrl_err=0.
2. addr=0x0FC0, beats=4 → two ARs: (0x0FC0, ARLEN=0), then (0x1000, ARLEN=2). No 4 KB crossing.
3. addr=0, beats=200, MAX_OUTSTANDING=2, RVALID held 0 → exactly 2 ARs (ARLEN=63, 63), then ARVALID=0. After RVALID is released, the remaining ARs are ARLEN=63 and 7; total 200 beats.
4. beats=32 with RRESP=2 on beat 3 → all 32 beats delivered, ctrl_err=1 at ctrl_done. Next start with clean responses → ctrl_err=0.
5. beats=0 → no ARVALID ever; ctrl_done pulses once, 3 cycles after start.
6. ap_rst asserted for 1 cycle mid-ISSUE (ARVALID=1) → next cycle ARVALID=0, busy=0, FSM in IDLE. A subsequent start (beats=8) completes normally.
